// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
// Holds the FSM encoding, writeback-source codes and the timeout defaults.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_WAIT_RD = 2'd2,
        S_DONE    = 2'd3
    } mem_state_e;

    localparam logic [1:0] WB_ALU     = 2'b00;
    localparam logic [1:0] WB_LOAD    = 2'b01;
    localparam logic [1:0] WB_PC1     = 2'b10;
    localparam logic [1:0] WB_ALU_ALT = 2'b11;

    localparam int unsigned TIMEOUT_DEFAULT = 15;
    localparam logic [31:0] TIMEOUT_RDATA   = 32'hDEADBEEF;

    // Link value is the 8-bit PC plus one, wrapping at 8'hFF.
    function automatic logic [31:0] wb_select(input logic [1:0]  sel,
                                              input logic [31:0] alu,
                                              input logic [31:0] ld,
                                              input logic [7:0]  pc);
        case (sel)
            WB_LOAD:            return ld;
            WB_PC1:             return {24'd0, pc + 8'd1};
            WB_ALU, WB_ALU_ALT: return alu;
            default:            return alu;
        endcase
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A bubble clears only the write enable so a
// stalled instruction never writes back twice; the data fields hold.
module mem_wb_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        bubble_i,
    input  logic        wen_i,
    input  logic [31:0] result_i,
    input  logic [4:0]  dest_i,
    input  logic [7:0]  pc_i,
    output logic        wen_o,
    output logic [31:0] result_o,
    output logic [4:0]  dest_o,
    output logic [7:0]  pc_o
);

    logic        wen_q;
    logic [31:0] result_q;
    logic [4:0]  dest_q;
    logic [7:0]  pc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wen_q    <= 1'b0;
            result_q <= '0;
            dest_q   <= '0;
            pc_q     <= '0;
        end else if (bubble_i) begin
            wen_q    <= 1'b0;
        end else begin
            wen_q    <= wen_i;
            result_q <= result_i;
            dest_q   <= dest_i;
            pc_q     <= pc_i;
        end
    end

    assign wen_o    = wen_q;
    assign result_o = result_q;
    assign dest_o   = dest_q;
    assign pc_o     = pc_q;

endmodule

// File: rtl/mem_stage_inst1.sv
// MEM pipeline stage: issues loads/stores on a ready/rvalid memory port and
// stalls upstream until done. Define MEM_TIMEOUT_EN for an abort-on-timeout path.
module mem_stage_inst1 import mem_stage_pkg::*; #(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] alu_out_m,
    input  logic [31:0] read_data2_m,
    input  logic [4:0]  dest_reg_m,
    input  logic [7:0]  pc_m,
    input  logic        mem_read_en_m,
    input  logic        mem_write_en_m,
    input  logic        reg_write_en_m,
    input  logic [1:0]  memto_reg_m,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        stall_m,
    output logic [31:0] wb_result,
    output logic [4:0]  wb_dest_reg,
    output logic        wb_reg_write_en,
    output logic [7:0]  wb_pc,
    output logic        mem_err
);

    mem_state_e  state_q, state_d;
    logic [31:0] ldbuf_q, ldbuf_d;
    logic        stall_raw;
    logic        tmo_hit;
    logic        is_mem, is_load;

    // Read wins when both enables are set.
    assign is_mem  = mem_read_en_m | mem_write_en_m;
    assign is_load = mem_read_en_m;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ldbuf_q <= '0;
        end else begin
            state_q <= state_d;
            ldbuf_q <= ldbuf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ldbuf_d   = ldbuf_q;
        stall_raw = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (is_mem) begin
                    stall_raw = 1'b1;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                stall_raw = 1'b1;
                if (dmem_ready) begin
                    state_d = is_load ? S_WAIT_RD : S_DONE;
                end else if (tmo_hit) begin
                    state_d = S_DONE;
                    ldbuf_d = TIMEOUT_RDATA;
                end
            end
            S_WAIT_RD: begin
                stall_raw = 1'b1;
                if (dmem_rvalid) begin
                    ldbuf_d = dmem_rdata;
                    state_d = S_DONE;
                end else if (tmo_hit) begin
                    state_d = S_DONE;
                    ldbuf_d = TIMEOUT_RDATA;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Reset must drop the stall even while a memory op is still presented.
    assign stall_m    = stall_raw & reset;
    assign dmem_req   = (state_q == S_REQ);
    assign dmem_we    = dmem_req & mem_write_en_m & ~mem_read_en_m;
    assign dmem_addr  = dmem_req ? alu_out_m : '0;
    assign dmem_wdata = dmem_req ? read_data2_m : '0;

`ifdef MEM_TIMEOUT_EN
    logic [7:0] cnt_q;
    logic       mem_err_q;

    assign tmo_hit = ((state_q == S_REQ && !dmem_ready) ||
                      (state_q == S_WAIT_RD && !dmem_rvalid)) &&
                     (cnt_q == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            mem_err_q <= tmo_hit;
            if (state_d != state_q)
                cnt_q <= '0;
            else if (state_q == S_REQ || state_q == S_WAIT_RD)
                cnt_q <= cnt_q + 8'd1;
        end
    end

    assign mem_err = mem_err_q;
`else
    assign tmo_hit = 1'b0;
    assign mem_err = 1'b0;
`endif

    // Out-of-range limits leave an empty marker block in the elaborated tree.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_out_of_range
    end

    mem_wb_reg u_wb (
        .clk      (clk),
        .reset    (reset),
        .bubble_i (stall_m),
        .wen_i    (reg_write_en_m),
        .result_i (wb_select(memto_reg_m, alu_out_m, ldbuf_q, pc_m)),
        .dest_i   (dest_reg_m),
        .pc_i     (pc_m),
        .wen_o    (wb_reg_write_en),
        .result_o (wb_result),
        .dest_o   (wb_dest_reg),
        .pc_o     (wb_pc)
    );

endmodule

// File: tb/tb_mem_stage_inst1.sv
// Self-checking bench for mem_stage_inst1: directed cases plus randomized ops
// checked against a transaction-level model of stall length and writeback.
module tb_mem_stage_inst1;

    logic        clk;
    logic        reset;
    logic [31:0] alu_out_m, read_data2_m, dmem_addr, dmem_wdata, dmem_rdata, wb_result;
    logic [4:0]  dest_reg_m, wb_dest_reg;
    logic [7:0]  pc_m, wb_pc;
    logic        mem_read_en_m, mem_write_en_m, reg_write_en_m;
    logic [1:0]  memto_reg_m;
    logic        dmem_req, dmem_we, dmem_ready, dmem_rvalid;
    logic        stall_m, wb_reg_write_en, mem_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_load = 32'd0;

    mem_stage_inst1 #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .alu_out_m(alu_out_m), .read_data2_m(read_data2_m),
        .dest_reg_m(dest_reg_m), .pc_m(pc_m),
        .mem_read_en_m(mem_read_en_m), .mem_write_en_m(mem_write_en_m),
        .reg_write_en_m(reg_write_en_m), .memto_reg_m(memto_reg_m),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .stall_m(stall_m), .wb_result(wb_result), .wb_dest_reg(wb_dest_reg),
        .wb_reg_write_en(wb_reg_write_en), .wb_pc(wb_pc), .mem_err(mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        alu_out_m = '0; read_data2_m = '0; dest_reg_m = '0; pc_m = '0;
        mem_read_en_m = 0; mem_write_en_m = 0; reg_write_en_m = 0; memto_reg_m = '0;
    endtask

    // Called just after a rising edge with the stage idle; returns just after
    // the edge that captures the writeback.
    task automatic run_op(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] dest,
                          input logic [7:0] pc, input logic rd, input logic wr, input logic rwe,
                          input logic [1:0] m2r, input int rdly, input int vdly,
                          input logic [31:0] rdata, input string tag);
        int stalls = 0, reqc = 0, waitc = 0, exp_stall;
        bit accepted = 0, done = 0;
        logic [31:0] exp_res, ld_val;
        logic [7:0]  pc1;
        alu_out_m = alu; read_data2_m = wd; dest_reg_m = dest; pc_m = pc;
        mem_read_en_m = rd; mem_write_en_m = wr; reg_write_en_m = rwe; memto_reg_m = m2r;
        exp_stall = (rd | wr) ? (2 + rdly + (rd ? vdly + 1 : 0)) : 0;
        ld_val = rd ? rdata : last_load;
        pc1 = pc + 8'd1;
        exp_res = (m2r == 2'b01) ? ld_val : (m2r == 2'b10) ? {24'd0, pc1} : alu;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (!stall_m) begin
                done = 1;
                dmem_ready = 0;
                dmem_rvalid = 0;
            end else begin
                stalls++;
                if (stalls > 1) check({tag, "_bubble"}, {31'd0, wb_reg_write_en}, 32'd0);
                if (dmem_req) begin
                    check({tag, "_addr"}, dmem_addr, alu);
                    check({tag, "_we"}, {31'd0, dmem_we}, {31'd0, wr & ~rd});
                    check({tag, "_wdata"}, dmem_wdata, wd);
                    dmem_ready = (reqc == rdly);
                    reqc++;
                    if (dmem_ready) accepted = 1;
                    dmem_rvalid = 1'($urandom_range(0, 1));
                    dmem_rdata = $urandom;
                end else begin
                    dmem_ready = 0;
                    if (accepted && rd) begin
                        dmem_rvalid = (waitc == vdly);
                        dmem_rdata = dmem_rvalid ? rdata : $urandom;
                        waitc++;
                    end else begin
                        dmem_rvalid = 1'($urandom_range(0, 1));
                        dmem_rdata = $urandom;
                    end
                end
            end
        end
        check({tag, "_completed"}, {31'd0, done}, 32'd1);
        check({tag, "_stall_cycles"}, stalls, exp_stall);
        check({tag, "_mem_err"}, {31'd0, mem_err}, 32'd0);
        @(posedge clk); #1;
        check({tag, "_wb_result"}, wb_result, exp_res);
        check({tag, "_wb_wen"}, {31'd0, wb_reg_write_en}, {31'd0, rwe});
        check({tag, "_wb_dest"}, {27'd0, wb_dest_reg}, {27'd0, dest});
        check({tag, "_wb_pc"}, {24'd0, wb_pc}, {24'd0, pc});
        if (rd) last_load = rdata;
    endtask

    initial begin
        reset = 0; dmem_ready = 0; dmem_rvalid = 0; dmem_rdata = '0;
        set_idle();
        #2;
        check("rst_stall", {31'd0, stall_m}, 32'd0);
        check("rst_req", {31'd0, dmem_req}, 32'd0);
        check("rst_we", {31'd0, dmem_we}, 32'd0);
        check("rst_err", {31'd0, mem_err}, 32'd0);
        check("rst_wb_result", wb_result, 32'd0);
        check("rst_wb_wen", {31'd0, wb_reg_write_en}, 32'd0);
        check("rst_wb_dest", {27'd0, wb_dest_reg}, 32'd0);
        check("rst_wb_pc", {24'd0, wb_pc}, 32'd0);
        @(negedge clk); reset = 1;
        @(posedge clk); #1;

        run_op(32'h10, 32'h0, 5'd3, 8'h20, 0, 0, 1, 2'b00, 0, 0, 32'h0, "alu");
        run_op(32'h40, 32'hA5A5A5A5, 5'd4, 8'h21, 0, 1, 0, 2'b00, 2, 0, 32'h0, "store_late");
        run_op(32'h80, 32'h0, 5'd5, 8'h22, 1, 0, 1, 2'b01, 0, 0, 32'h12345678, "load");
        run_op(32'h77, 32'h0, 5'd6, 8'hFF, 0, 0, 1, 2'b10, 0, 0, 32'h0, "pc_wrap");
        run_op(32'h55, 32'h99, 5'd7, 8'h30, 0, 1, 1, 2'b00, 0, 0, 32'h0, "store_rwe");
        run_op(32'h84, 32'h0, 5'd8, 8'h31, 1, 1, 1, 2'b01, 1, 2, 32'hCAFE0001, "rd_and_wr");

        for (int i = 0; i < 40; i++) begin
            int kind = $urandom_range(0, 3);
            run_op($urandom, $urandom, 5'($urandom), 8'($urandom),
                   kind == 1 || kind == 3, kind == 2 || kind == 3, 1'($urandom_range(0, 1)),
                   2'($urandom), $urandom_range(0, 3), $urandom_range(0, 2), $urandom, "rand");
        end

        // Reset while the load is waiting for read data.
        alu_out_m = 32'h88; dest_reg_m = 5'd9; pc_m = 8'h40;
        mem_read_en_m = 1; reg_write_en_m = 1; memto_reg_m = 2'b01;
        @(negedge clk); dmem_ready = 0; dmem_rvalid = 0;
        @(negedge clk); dmem_ready = 1;
        @(negedge clk); dmem_ready = 0;
        check("waitrd_stall", {31'd0, stall_m}, 32'd1);
        check("waitrd_req", {31'd0, dmem_req}, 32'd0);
        #2 reset = 0;
        set_idle();
        #1;
        check("midrst_stall", {31'd0, stall_m}, 32'd0);
        check("midrst_req", {31'd0, dmem_req}, 32'd0);
        check("midrst_err", {31'd0, mem_err}, 32'd0);
        check("midrst_wb_result", wb_result, 32'd0);
        check("midrst_wb_wen", {31'd0, wb_reg_write_en}, 32'd0);
        check("midrst_wb_pc", {24'd0, wb_pc}, 32'd0);
        @(negedge clk); reset = 1; dmem_rvalid = 1; dmem_rdata = 32'hBAD0BAD0;
        @(negedge clk); dmem_rvalid = 0;
        check("late_rvalid_stall", {31'd0, stall_m}, 32'd0);
        check("late_rvalid_req", {31'd0, dmem_req}, 32'd0);
        check("late_rvalid_wen", {31'd0, wb_reg_write_en}, 32'd0);
        last_load = 32'd0;
        @(posedge clk); #1;
        run_op(32'h1, 32'h0, 5'd10, 8'h41, 0, 0, 1, 2'b01, 0, 0, 32'h0, "ldbuf_cleared");

`ifdef MEM_TIMEOUT_EN
        begin
            int stalls = 0;
            bit done = 0;
            alu_out_m = 32'hC0; dest_reg_m = 5'd11; pc_m = 8'h50;
            mem_read_en_m = 1; reg_write_en_m = 1; memto_reg_m = 2'b01;
            dmem_ready = 0;
            for (int c = 0; c < 50 && !done; c++) begin
                @(negedge clk);
                if (!stall_m) done = 1; else stalls++;
            end
            check("tmo_completed", {31'd0, done}, 32'd1);
            check("tmo_stall_cycles", stalls, 32'd5);
            check("tmo_mem_err", {31'd0, mem_err}, 32'd1);
            @(posedge clk); #1;
            check("tmo_wb_result", wb_result, 32'hDEADBEEF);
            check("tmo_err_pulse", {31'd0, mem_err}, 32'd0);
            set_idle();
            @(negedge clk);
            check("tmo_idle", {31'd0, stall_m}, 32'd0);
            @(posedge clk); #1;
        end
`endif

        set_idle();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_inst1.md
MEM_STAGE_INST1 -- requirements
Module: mem_stage_inst1

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15, SHALL set the memory-wait cycle limit (used only under MEM_TIMEOUT_EN); range 1..255.
REQ-002 clk  in  1  SHALL be the clock; all state changes on its rising edge.
REQ-003 reset  in  1  SHALL be the asynchronous, active-low reset.
REQ-004 alu_out_m  in  32  SHALL carry the ALU result, also used as the memory address.
REQ-005 read_data2_m  in  32  SHALL carry the store data.
REQ-006 dest_reg_m  in  5  SHALL carry the destination register.
REQ-007 pc_m  in  8  SHALL carry the instruction PC.
REQ-008 mem_read_en_m, mem_write_en_m, reg_write_en_m  in  1 each  SHALL carry the MEM-stage controls.
REQ-009 memto_reg_m  in  2  SHALL select the writeback source: 00 ALU, 01 load data, 10 pc_m+1, 11 ALU.
REQ-010 dmem_req  out  1  SHALL be the data-memory request valid.
REQ-011 dmem_we  out  1  SHALL mark the request as a write.
REQ-012 dmem_addr  out  32  SHALL drive the request address.
REQ-013 dmem_wdata  out  32  SHALL drive the write data.
REQ-014 dmem_ready  in  1  SHALL signal request accept.
REQ-015 dmem_rvalid  in  1  SHALL signal read data valid.
REQ-016 dmem_rdata  in  32  SHALL carry the read data.
REQ-017 stall_m  out  1  SHALL request upstream stages to hold; upstream keeps all *_m inputs stable while it is 1.
REQ-018 wb_result  out  32  SHALL carry the registered writeback value.
REQ-019 wb_dest_reg  out  5  SHALL carry the registered destination register.
REQ-020 wb_reg_write_en  out  1  SHALL carry the registered write enable.
REQ-021 wb_pc  out  8  SHALL carry the registered PC.
REQ-022 mem_err  out  1  SHALL pulse for one cycle on a memory timeout.

Function
REQ-023 FSM states SHALL be IDLE, REQ, WAIT_RD and DONE.
REQ-024 IDLE with no memory op: stall_m=0; WB outputs capture the inputs each edge (one-cycle latency).
REQ-025 IDLE with a memory op: stall_m=1 combinationally, next state REQ.
REQ-026 If mem_read_en_m and mem_write_en_m are both 1, the op SHALL be treated as a load.
REQ-027 REQ state: dmem_req=1, dmem_we=store, dmem_addr=alu_out_m, dmem_wdata=read_data2_m.
REQ-028 REQ state: all dmem_* outputs SHALL be held stable until dmem_ready.
REQ-029 On dmem_ready in REQ: a store SHALL go to DONE; a load SHALL go to WAIT_RD.
REQ-030 WAIT_RD: dmem_req=0; on dmem_rvalid, dmem_rdata SHALL be captured into the load buffer and the state SHALL go to DONE.
REQ-031 dmem_rvalid outside WAIT_RD SHALL be ignored.
REQ-032 DONE: stall_m=0; WB outputs capture the result at the closing edge; next state IDLE.
REQ-033 Every edge with stall_m=1 SHALL load wb_reg_write_en<=0 (bubble), so there is no duplicate writeback.
REQ-034 pc_m+1 SHALL be 8-bit and wrap (8'hFF -> 8'h00).
REQ-035 A store with reg_write_en_m=1 SHALL write back the ALU value per memto_reg_m.
REQ-036 Minimum stall SHALL be 2 cycles for a store and 3 cycles for a load (rvalid in the cycle after ready).

Reset
REQ-037 reset low SHALL immediately force IDLE, dmem_req=0, dmem_we=0, stall_m=0, mem_err=0, and all wb_* and the load buffer to 0, including mid-transaction.
REQ-038 After reset, no request SHALL be replayed; a late dmem_rvalid SHALL be ignored.

Configuration
REQ-039 With MEM_TIMEOUT_EN defined, a counter SHALL run in REQ/WAIT_RD, cleared on entry.
REQ-040 With MEM_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES SHALL go to DONE with load data 32'hDEADBEEF and pulse mem_err.
REQ-041 Without MEM_TIMEOUT_EN, there SHALL be no counter, mem_err SHALL be tied 0, and the FSM SHALL wait indefinitely.

Structure
REQ-042 Package mem_stage_pkg SHALL hold the FSM state enum, the memto_reg encodings, the TIMEOUT default and the 32'hDEADBEEF constant.
REQ-043 Sub-module mem_wb_reg SHALL implement the WB output register with the bubble input.

Verification
REQ-044 ALU op (alu_out_m=32'h10, reg_write_en_m=1, memto_reg_m=00) -> wb_result=32'h10 next edge, stall_m never 1.
REQ-045 Store to addr 32'h40, data 32'hA5A5A5A5, dmem_ready held 2 cycles late -> request stable throughout, stall_m high for exactly 4 cycles, wb_reg_write_en=0.
REQ-046 Load from 32'h80, ready immediately, rvalid with 32'h12345678 one cycle later -> stall_m high 3 cycles, wb_result=32'h12345678, one write.
REQ-047 pc_m=8'hFF, memto_reg_m=10 -> wb_result=32'h0.
REQ-048 Reset asserted in WAIT_RD, then rvalid pulses after reset -> IDLE, all outputs 0, rvalid ignored.
REQ-049 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, dmem_ready never asserted -> mem_err pulse, wb_result=32'hDEADBEEF, return to IDLE.
